root_seq: RTL and testbench
===========================

ROOT_SEQ -- requirements
Module: root_seq

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 64, the maximum number of WAIT cycles before a job is aborted.
REQ-002 The block SHALL have the port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have the port rst_n_i, input, 1 bit: synchronous active-low reset.
REQ-004 The block SHALL have the port req_valid_i, input, 1 bit: an operand request is offered.
REQ-005 The block SHALL have the port req_ready_o, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have the port req_data_i, input, 32 bits: the unsigned operand x.
REQ-007 The block SHALL have the port rsp_valid_o, output, 1 bit: a result is presented.
REQ-008 The block SHALL have the port rsp_ready_i, input, 1 bit: the consumer accepts the result.
REQ-009 The block SHALL have the port rsp_data_o, output, 32 bits: floor(sqrt(x)), or 0 on error.
REQ-010 The block SHALL have the port rsp_err_o, output, 1 bit: the job timed out; qualified by rsp_valid_o.
REQ-011 The block SHALL have the port root_rst_o, output, 1 bit: active-high synchronous reset to the square-root unit.
REQ-012 The block SHALL have the port root_start_o, output, 1 bit: start pulse to the square-root unit.
REQ-013 The block SHALL have the port root_x_o, output, 32 bits: operand to the square-root unit.
REQ-014 The block SHALL have the port root_y_i, input, 32 bits: square-root unit result.
REQ-015 The block SHALL have the port root_state_i, input, 3 bits: square-root unit status (0 ready, 1 work, 2 result held).
REQ-016 The block SHALL have the port done_cnt_o, output, 16 bits: count of completed jobs, error jobs included.

Function
REQ-017 The FSM SHALL have the states IDLE, CLR, START, WAIT and RESP.
REQ-018 req_ready_o SHALL be 1 only in IDLE; a handshake (req_valid_i && req_ready_o) SHALL latch req_data_i and move to CLR.
REQ-019 CLR SHALL last exactly 1 cycle with root_rst_o=1, then go to START; the unit does not self-clear its result register, so every job is preceded by CLR.
REQ-020 START SHALL last exactly 1 cycle with root_start_o=1 and root_x_o equal to the latched operand, then go to WAIT with the timeout counter cleared.
REQ-021 root_x_o SHALL hold the latched operand from CLR through WAIT; root_start_o SHALL be 0 outside START.
REQ-022 In WAIT, when root_state_i==2, the block SHALL capture root_y_i into rsp_data_o, set rsp_err_o=0, and go to RESP.
REQ-023 In WAIT, the counter SHALL increment each cycle; when it reaches TIMEOUT without root_state_i==2, the block SHALL set rsp_data_o=0 and rsp_err_o=1, then go to RESP.
REQ-024 If done and timeout occur in the same cycle, done SHALL win.
REQ-025 rsp_valid_o SHALL be 1 throughout RESP, with rsp_data_o and rsp_err_o stable until the rsp_valid_o && rsp_ready_i handshake, which returns the FSM to IDLE.
REQ-026 done_cnt_o SHALL increment by 1 at each response handshake and wrap from 0xFFFF to 0.
REQ-027 Latency from request handshake to rsp_valid_o SHALL be exactly 3 + (number of WAIT cycles); with a nominal unit, that is 22 cycles or fewer.
REQ-028 A new request SHALL NOT be accepted in the cycle of a response handshake; there is one job in flight at most.

Reset
REQ-029 While rst_n_i=0 at a clock edge, the block SHALL set state=IDLE, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, root_start_o=0, root_x_o=0, done_cnt_o=0, and the counter to 0.
REQ-030 root_rst_o SHALL be 1 during reset, so the square-root unit is cleared together with the block.
REQ-031 A reset in any state, including mid-WAIT, SHALL abandon the job with no response issued and req_ready_o=1 on the first cycle after release.

Structure
REQ-032 A shared package root_pkg SHALL hold the FSM state enum, the data width constant 32, the root status codes (0, 1, 2) and the TIMEOUT default.
REQ-033 No sub-module SHALL be used; the square-root unit is instantiated as a sibling at the top level, not inside this block.

Verification
REQ-034 The bench SHALL check: x=144 -> rsp_data_o=12, rsp_err_o=0, done_cnt_o=1.
REQ-035 The bench SHALL check: x=0 -> rsp_data_o=0, and x=0xFFFFFFFF -> rsp_data_o=0x0000FFFF.
REQ-036 The bench SHALL check back-to-back jobs x=16 then x=17 -> responses 4 and 4, with root_rst_o pulsed once before each start.
REQ-037 The bench SHALL check rsp_ready_i held at 0 for 10 cycles -> rsp_valid_o=1 and rsp_data_o stable, req_ready_o=0, and IDLE one cycle after the handshake.
REQ-038 The bench SHALL check root_state_i tied to 0 with TIMEOUT=8 -> a response after 8 WAIT cycles with rsp_err_o=1, rsp_data_o=0, and done_cnt_o incremented.
REQ-039 The bench SHALL check rst_n_i=0 for 1 cycle mid-WAIT -> no rsp_valid_o, done_cnt_o=0, root_rst_o=1 during reset, and a following job x=81 -> 9.

Source files
------------

// File: rtl/root_pkg.sv
// root_pkg: shared types and constants for the square-root job sequencer
package root_pkg;
  localparam int DW = 32;
  localparam int TIMEOUT_DEF = 64;
  localparam logic [2:0] ST_READY = 3'd0;
  localparam logic [2:0] ST_WORK = 3'd1;
  localparam logic [2:0] ST_HELD = 3'd2;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;
endpackage

// File: rtl/root_seq.sv
// root_seq: runs one square-root job per request through clear, start, wait and response
module root_seq
  import root_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [DW-1:0] req_data_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_data_o,
  output logic          rsp_err_o,
  output logic          root_rst_o,
  output logic          root_start_o,
  output logic [DW-1:0] root_x_o,
  input  logic [DW-1:0] root_y_i,
  input  logic [2:0]    root_state_i,
  output logic [15:0]   done_cnt_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DW-1:0] x_q, data_q;
  logic err_q;
  logic [15:0] done_q;
  logic hit, expire;
  assign hit = root_state_i == ST_HELD;
  assign expire = cnt == CW'(TIMEOUT - 1);
  assign req_ready_o = state == S_IDLE;
  assign rsp_valid_o = state == S_RESP;
  assign root_rst_o = !rst_n_i || state == S_CLR;
  assign root_start_o = state == S_START;
  assign root_x_o = x_q;
  assign rsp_data_o = data_q;
  assign rsp_err_o = err_q;
  assign done_cnt_o = done_q;
  // next state: a finished unit is checked before the timeout so done wins a tie
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = req_valid_i ? S_CLR : S_IDLE;
      S_CLR:   state_nx = S_START;
      S_START: state_nx = S_WAIT;
      S_WAIT:  state_nx = (hit || expire) ? S_RESP : S_WAIT;
      S_RESP:  state_nx = rsp_ready_i ? S_IDLE : S_RESP;
      default: state_nx = S_IDLE;
    endcase
  end
  // state, operand latch, wait counter, response capture and job counter
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state  <= S_IDLE;
      cnt    <= '0;
      x_q    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      done_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= state == S_WAIT ? cnt + 1'b1 : '0;
      if (state == S_IDLE && req_valid_i) x_q <= req_data_i;
      if (state == S_WAIT && (hit || expire)) begin
        data_q <= hit ? root_y_i : '0;
        err_q  <= !hit;
      end
      if (state == S_RESP && rsp_ready_i) done_q <= done_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_root_seq.sv
// tb_root_seq: table-driven and random checks of root_seq against a behavioural square-root unit
module tb_root_seq;
  localparam int TO = 8;
  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] req_data_i = '0;
  logic        req_ready_o, rsp_valid_o, rsp_err_o, root_rst_o, root_start_o;
  logic [31:0] rsp_data_o, root_x_o, root_y_i;
  logic [2:0]  root_state_i;
  logic [15:0] done_cnt_o;

  always #5 clk_i = ~clk_i;

  root_seq #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o), .root_rst_o(root_rst_o), .root_start_o(root_start_o),
    .root_x_o(root_x_o), .root_y_i(root_y_i), .root_state_i(root_state_i),
    .done_cnt_o(done_cnt_o)
  );

  int n_chk = 0;
  int n_pass = 0;
  int exp_done = 0;
  int job_lat = 0;

  typedef struct {
    logic [31:0] x;
    int          lat;
    int          rw;
    logic [31:0] ed;
    logic        ee;
  } vec_t;
  vec_t vecs[10];

  // largest r with r*r <= x, by binary search over 64-bit products
  function automatic logic [31:0] isqrt(input logic [31:0] x);
    longint lo = 0;
    longint hi = 65536;
    longint mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= longint'(x)) lo = mid;
      else hi = mid;
    end
    return 32'(lo);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // square-root unit stand-in: job_lat cycles into WAIT it holds the result; negative lat never leaves ready
  logic [2:0]  u_st = 3'd0;
  logic [31:0] u_y = '0;
  int          u_cnt = 0;
  assign root_state_i = u_st;
  assign root_y_i = u_y;
  always @(posedge clk_i) begin
    if (root_rst_o) begin
      u_st <= 3'd0;
      u_y  <= '0;
    end else if (root_start_o && job_lat >= 0) begin
      if (job_lat == 0) begin
        u_st <= 3'd2;
        u_y  <= isqrt(root_x_o);
      end else begin
        u_st  <= 3'd1;
        u_cnt <= job_lat;
      end
    end else if (u_st == 3'd1) begin
      if (u_cnt == 1) begin
        u_st <= 3'd2;
        u_y  <= isqrt(root_x_o);
      end else u_cnt <= u_cnt - 1;
    end
  end

  int          n_clr = 0;
  int          n_start = 0;
  logic [31:0] start_x = '0;
  logic        order_ok = 1'b0;
  logic        prev_clr = 1'b0;
  always @(negedge clk_i) begin
    if (root_start_o) begin
      n_start++;
      start_x = root_x_o;
      order_ok = prev_clr;
    end
    if (rst_n_i && root_rst_o) n_clr++;
    prev_clr = rst_n_i && root_rst_o;
  end

  task automatic run_job(input logic [31:0] x, input int lat, input int rw,
                         input logic [31:0] ed, input logic ee);
    int k;
    int wc;
    logic bad_x, bad_hold, e0;
    logic [31:0] d0;
    wc = (lat < 0 || lat >= TO) ? TO : lat + 1;
    job_lat = lat;
    n_clr = 0;
    n_start = 0;
    order_ok = 1'b0;
    req_data_i = x;
    req_valid_i = 1'b1;
    k = 0;
    while (!req_ready_o && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    chk("req_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    k = 1;
    bad_x = 1'b0;
    while (!rsp_valid_o && k < 40) begin
      if (root_x_o !== x) bad_x = 1'b1;
      @(negedge clk_i);
      k++;
    end
    chk("latency", 32'(k), 32'(3 + wc));
    chk("rsp_data", rsp_data_o, ed);
    chk("rsp_err", 32'(rsp_err_o), 32'(ee));
    chk("x_hold", 32'(bad_x), 32'd0);
    chk("clr_pulses", 32'(n_clr), 32'd1);
    chk("start_pulses", 32'(n_start), 32'd1);
    chk("start_x", start_x, x);
    chk("clr_before_start", 32'(order_ok), 32'd1);
    d0 = rsp_data_o;
    e0 = rsp_err_o;
    bad_hold = 1'b0;
    repeat (rw) begin
      @(negedge clk_i);
      if (!rsp_valid_o || req_ready_o || rsp_data_o !== d0 || rsp_err_o !== e0) bad_hold = 1'b1;
    end
    if (rw > 0) chk("rsp_hold", 32'(bad_hold), 32'd0);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    exp_done++;
    chk("idle_after_hs", 32'(req_ready_o), 32'd1);
    chk("valid_drop", 32'(rsp_valid_o), 32'd0);
    chk("done_cnt", 32'(done_cnt_o), 32'(exp_done & 16'hFFFF));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] x;
    int lat;
    logic seen;
    vecs[0] = '{32'd144,        2,  0, 32'd12,       1'b0};
    vecs[1] = '{32'd0,          0,  1, 32'd0,        1'b0};
    vecs[2] = '{32'hFFFF_FFFF,  5,  2, 32'h0000FFFF, 1'b0};
    vecs[3] = '{32'd16,         3,  0, 32'd4,        1'b0};
    vecs[4] = '{32'd17,         3,  0, 32'd4,        1'b0};
    vecs[5] = '{32'd99,         4, 10, 32'd9,        1'b0};
    vecs[6] = '{32'd1000000,    7,  1, 32'd1000,     1'b0};
    vecs[7] = '{32'd25,         8,  0, 32'd0,        1'b1};
    vecs[8] = '{32'd50,        -1,  2, 32'd0,        1'b1};
    vecs[9] = '{32'd2,          0,  0, 32'd1,        1'b0};

    repeat (3) @(negedge clk_i);
    chk("rst_root_rst", 32'(root_rst_o), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_root_start", 32'(root_start_o), 32'd0);
    chk("rst_root_x", root_x_o, 32'd0);
    chk("rst_rsp_data", rsp_data_o, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("rst_done_cnt", 32'(done_cnt_o), 32'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("rel_root_rst", 32'(root_rst_o), 32'd0);
    chk("rel_req_ready", 32'(req_ready_o), 32'd1);

    for (int i = 0; i < 10; i++) run_job(vecs[i].x, vecs[i].lat, vecs[i].rw, vecs[i].ed, vecs[i].ee);

    for (int i = 0; i < 16; i++) begin
      x = $urandom;
      if ($urandom_range(0, 3) == 0) x = x & 32'hFF;
      lat = int'($urandom_range(0, 10)) - 1;
      run_job(x, lat, int'($urandom_range(0, 3)),
              (lat >= 0 && lat < TO) ? isqrt(x) : 32'd0, !(lat >= 0 && lat < TO));
    end

    job_lat = -1;
    req_data_i = 32'd200;
    req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    chk("midrst_root_rst", 32'(root_rst_o), 32'd1);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    chk("midrst_req_ready", 32'(req_ready_o), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("midrst_done_cnt", 32'(done_cnt_o), 32'd0);
    exp_done = 0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk_i);
      if (rsp_valid_o) seen = 1'b1;
    end
    chk("midrst_abandon", 32'(seen), 32'd0);
    run_job(32'd81, 3, 0, 32'd9, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
